// File: rtl/alu_result_queue_pkg.sv
// Shared ALU definitions for the result queue: opcodes, flag bit positions,
// queue entry layout and the beat-state encoding.
package alu_result_queue_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_SHL  = 4'd3,
        ALU_SHR  = 4'd4,
        ALU_ROL  = 4'd5,
        ALU_ROR  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_NOR  = 4'd9,
        ALU_NAND = 4'd10,
        ALU_XOR  = 4'd11,
        ALU_XNOR = 4'd12,
        ALU_NOT  = 4'd13,
        ALU_EQ   = 4'd14,
        ALU_NEG  = 4'd15
    } alu_op_e;

    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_V = 0;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] out1;
        logic [15:0] out0;
        logic [2:0]  flags;
    } alu_entry_t;

    localparam int unsigned ALU_ENT_W = $bits(alu_entry_t);

    typedef enum logic {
        BEAT_LO = 1'b0,
        BEAT_HI = 1'b1
    } beat_e;

endpackage

// File: rtl/alu_result_queue_if.sv
// ALU-result capture port and drained beat port of the result queue.
interface alu_result_queue_if;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sel;
    logic [15:0] in_out1;
    logic [15:0] in_out0;
    logic        in_c;
    logic        in_z;
    logic        in_v;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_sel;
    logic [2:0]  out_flags;
    logic        out_last;

    modport master (
        output in_valid, in_sel, in_out1, in_out0, in_c, in_z, in_v, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_flags, out_last
    );

    modport slave (
        input  in_valid, in_sel, in_out1, in_out0, in_c, in_z, in_v, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_flags, out_last
    );

endinterface

// File: rtl/alu_result_queue_fifo.sv
// Register-array synchronous FIFO with registered occupancy count and a
// combinational view of the head entry.
module alu_sync_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_queue.sv
// Queues ALU results and drains them as 16-bit beats (MUL as two beats),
// tracking sticky carry/overflow and a retired-entry counter.
module alu_result_queue
    import alu_result_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_queue_if.slave    bus,
    input  logic                 clr_sticky,
    output logic                 sticky_c,
    output logic                 sticky_v,
    output logic [CNT_W-1:0]     retired_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    alu_entry_t     wr_entry;
    alu_entry_t     head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;
    logic           push;
    logic           pop;
    logic           handshake;
    logic           is_last;
    beat_e          beat;
    beat_e          beat_nxt;

    assign wr_entry = '{sel: bus.in_sel, out1: bus.in_out1, out0: bus.in_out0,
                        flags: {bus.in_c, bus.in_z, bus.in_v}};

    // Ready comes from the registered count only, so a full queue refuses a
    // push even when the head is retiring in the same cycle.
    assign bus.in_ready  = (fifo_count < DEPTH_CNT);
    assign bus.out_valid = !fifo_empty;
    assign push          = bus.in_valid && bus.in_ready && !fifo_full;

    alu_sync_fifo #(
        .WIDTH (ALU_ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat <= BEAT_LO;
        end else begin
            beat <= beat_nxt;
        end
    end

    always_comb begin
        beat_nxt      = beat;
        is_last       = (head.sel != ALU_MUL) || (beat == BEAT_HI);
        handshake     = bus.out_valid && bus.out_ready;
        pop           = handshake && is_last;
        bus.out_data  = '0;
        bus.out_sel   = '0;
        bus.out_flags = '0;
        bus.out_last  = 1'b0;
        if (handshake) begin
            beat_nxt = is_last ? BEAT_LO : BEAT_HI;
        end
        if (bus.out_valid) begin
            bus.out_data  = (beat == BEAT_HI) ? head.out1 : head.out0;
            bus.out_sel   = head.sel;
            bus.out_flags = head.flags;
            bus.out_last  = is_last;
        end
    end

    // A clear coinciding with a retire still keeps the retiring entry's flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_c    <= 1'b0;
            sticky_v    <= 1'b0;
            retired_cnt <= '0;
        end else if (pop) begin
            sticky_c    <= (sticky_c && !clr_sticky) || head.flags[FLG_C];
            sticky_v    <= (sticky_v && !clr_sticky) || head.flags[FLG_V];
            retired_cnt <= retired_cnt + 1'b1;
        end else if (clr_sticky) begin
            sticky_c    <= 1'b0;
            sticky_v    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: single beats, MUL beats, backpressure,
// sticky flags, counter wrap and mid-stream reset.
module tb_alu_result_queue;

    logic        clk;
    logic        rst_n;
    logic        clr_sticky;
    logic        sticky_c;
    logic        sticky_v;
    logic [15:0] retired_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    alu_result_queue_if bus ();

    alu_result_queue #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .clr_sticky  (clr_sticky),
        .sticky_c    (sticky_c),
        .sticky_v    (sticky_v),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [15:0] o1,
                         input logic [15:0] o0, input logic [2:0] f);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_out1  = o1;
        bus.in_out0  = o0;
        {bus.in_c, bus.in_z, bus.in_v} = f;
    endtask

    task automatic idle_in();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 3'b000);
    endtask

    // Streams n single-beat entries with out_ready held high, then waits for drain.
    task automatic stream(input int unsigned n);
        int unsigned pushed;
        int unsigned budget;
        pushed = 0;
        budget = 0;
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd0, 16'h0, 16'h5, 3'b000);
        while (pushed < n && budget < n + 16) begin
            if (bus.in_ready) pushed++;
            step();
            budget++;
        end
        idle_in();
        check_eq("stream_pushed", pushed, n);
        budget = 0;
        while (bus.out_valid && budget < 16) begin
            step();
            budget++;
        end
        check_eq("stream_drained", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        clr_sticky = 1'b0;
        bus.out_ready = 1'b0;
        idle_in();
        step();
        step();
        rst_n = 1'b1;

        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_retired", {16'd0, retired_cnt}, 32'd0);
        check_eq("rst_sticky", {30'd0, sticky_c, sticky_v}, 32'd0);
        check_eq("rst_out_data", {16'd0, bus.out_data}, 32'd0);

        // ADD 1+2
        drive(1'b1, 4'd0, 16'h0, 16'd3, 3'b000);
        bus.out_ready = 1'b1;
        step();
        idle_in();
        check_eq("add_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("add_data", {16'd0, bus.out_data}, 32'd3);
        check_eq("add_last", {31'd0, bus.out_last}, 32'd1);
        check_eq("add_flags", {29'd0, bus.out_flags}, 32'd0);
        check_eq("add_sel", {28'd0, bus.out_sel}, 32'd0);
        step();
        check_eq("add_retired", {16'd0, retired_cnt}, 32'd1);
        check_eq("add_empty", {31'd0, bus.out_valid}, 32'd0);

        // MUL 0x0100 * 0x0100
        drive(1'b1, 4'd2, 16'h0001, 16'h0000, 3'b000);
        step();
        idle_in();
        check_eq("mul_lo_data", {16'd0, bus.out_data}, 32'h0000);
        check_eq("mul_lo_last", {31'd0, bus.out_last}, 32'd0);
        check_eq("mul_lo_sel", {28'd0, bus.out_sel}, 32'd2);
        step();
        check_eq("mul_hi_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("mul_hi_data", {16'd0, bus.out_data}, 32'h0001);
        check_eq("mul_hi_last", {31'd0, bus.out_last}, 32'd1);
        check_eq("mul_no_early_pop", {16'd0, retired_cnt}, 32'd1);
        step();
        check_eq("mul_retired", {16'd0, retired_cnt}, 32'd2);
        check_eq("mul_empty", {31'd0, bus.out_valid}, 32'd0);

        // Fill to DEPTH with consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_ready", {31'd0, bus.in_ready}, 32'd1);
            drive(1'b1, 4'd7, 16'h0, 16'h0010 + 16'(i), 3'b010);
            step();
        end
        check_eq("full_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 4'd7, 16'h0, 16'h0099, 3'b000);
        step();
        check_eq("full_ready_hold", {31'd0, bus.in_ready}, 32'd0);
        check_eq("full_head_stable", {16'd0, bus.out_data}, 32'h0010);
        idle_in();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq("drain_data", {16'd0, bus.out_data}, 32'h0010 + 32'(i));
            check_eq("drain_flags", {29'd0, bus.out_flags}, 32'b010);
            step();
            check_eq("drain_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        check_eq("drain_empty", {31'd0, bus.out_valid}, 32'd0);
        check_eq("drain_retired", {16'd0, retired_cnt}, 32'd6);

        // Backpressure on the HI beat of a MUL
        drive(1'b1, 4'd2, 16'hBEEF, 16'h1234, 3'b000);
        step();
        idle_in();
        check_eq("bp_lo_data", {16'd0, bus.out_data}, 32'h1234);
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_hi_data", {16'd0, bus.out_data}, 32'hBEEF);
            check_eq("bp_hi_last", {31'd0, bus.out_last}, 32'd1);
            check_eq("bp_hi_valid", {31'd0, bus.out_valid}, 32'd1);
            step();
        end
        check_eq("bp_held_cnt", {16'd0, retired_cnt}, 32'd6);
        bus.out_ready = 1'b1;
        step();
        check_eq("bp_retired", {16'd0, retired_cnt}, 32'd7);
        check_eq("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Sticky flags
        drive(1'b1, 4'd0, 16'h0, 16'h0, 3'b100);
        step();
        idle_in();
        step();
        check_eq("sticky_c_set", {30'd0, sticky_c, sticky_v}, 32'b10);
        drive(1'b1, 4'd1, 16'h0, 16'h8000, 3'b001);
        step();
        idle_in();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check_eq("sticky_clr_retire", {30'd0, sticky_c, sticky_v}, 32'b01);
        check_eq("sticky_retired", {16'd0, retired_cnt}, 32'd9);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check_eq("sticky_clr_only", {30'd0, sticky_c, sticky_v}, 32'b00);

        // Counter wrap: 9 + 65526 = 0xFFFF, then two more
        stream(65526);
        check_eq("cnt_ffff", {16'd0, retired_cnt}, 32'hFFFF);
        stream(1);
        check_eq("cnt_wrap0", {16'd0, retired_cnt}, 32'd0);
        stream(1);
        check_eq("cnt_wrap1", {16'd0, retired_cnt}, 32'd1);

        // Reset with two entries queued
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd8, 16'h0, 16'hAAAA, 3'b101);
        step();
        step();
        idle_in();
        check_eq("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("mid_rst_cnt", {16'd0, retired_cnt}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset after the LO beat of a MUL leaves beat at LO
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd2, 16'h7777, 16'h6666, 3'b000);
        step();
        idle_in();
        step();
        check_eq("half_mul_hi", {16'd0, bus.out_data}, 32'h7777);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 4'd0, 16'h0, 16'd5, 3'b000);
        step();
        idle_in();
        check_eq("after_rst_data", {16'd0, bus.out_data}, 32'd5);
        check_eq("after_rst_last", {31'd0, bus.out_last}, 32'd1);
        step();
        check_eq("after_rst_cnt", {16'd0, retired_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
